// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - state_e         : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   - MIN/MAX_WIDTH   : supported operand width range
//   - width_is_legal  : elaboration-time check of the WIDTH parameter
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_is_legal(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_add_data.sv
// ---------------------------------------------------------------------------
// full_add_data
// One-bit full-add cell, purely combinational.
// Ports:
//   a, b  : operand bits
//   cin   : incoming carry
//   s     : sum bit   = a ^ b ^ cin
//   c     : carry out = majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_add_data (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder with carry-in. Operands are captured on an
// accepted start, added LSB-first over WIDTH clock cycles through a single
// full-add cell and a carry flip-flop, and the result is held until the next
// accepted start.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, only sampled in IDLE
//   a, b   : operands (WIDTH bits), captured on accepted start
//   cin    : carry-in, captured on accepted start
//   busy   : high in SHIFT and DONE
//   done   : one-cycle strobe, sum/cout valid from this cycle on
//   sum    : registered result (WIDTH bits)
//   cout   : registered final carry
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  generate
    if (!width_is_legal(WIDTH)) begin : g_bad_width
      $error("serial_adder: WIDTH must be within 2..32");
    end
  endgenerate

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  // Combinational outputs of the full-add cell for the current bit position.
  logic               sum_bit_d;
  logic               carry_d;

  full_add_data u_full_add (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (sum_bit_d),
    .c   (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          // Bits arrive LSB first; inserting at the MSB and shifting right
          // leaves bit 0 in place after the last of WIDTH shifts.
          sum_q   <= {sum_bit_d, sum_q[WIDTH-1:1]};
          carry_q <= carry_d;
          if (cnt_q == CNT_LAST) begin
            // Counter holds at its last value; it is reloaded on the next start.
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Directed and random checks of serial_adder (WIDTH=8). Expected results are
// pushed to a scoreboard queue when an operation is accepted and popped by a
// monitor on every done strobe.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  logic [WIDTH:0] sb[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every done strobe must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [WIDTH:0] exp_r;
        exp_r = sb.pop_front();
        check("result", {23'd0, cout, sum}, {23'd0, exp_r});
        $display("[TB] done: sum=%0h cout=%0b expected=%0h", sum, cout, exp_r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from IDLE. With poke set, start is held high with other
  // operands throughout SHIFT and DONE; it must be ignored.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv, input bit poke);
    int n;
    int busy_n;
    int d0;
    logic [WIDTH:0] exp_r;
    exp_r = (WIDTH+1)'(av) + (WIDTH+1)'(bv) + (WIDTH+1)'(cv);
    check("idle_before", 32'(busy), 32'd0);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    sb.push_back(exp_r);
    d0 = done_cnt;
    if (poke) begin
      a = 8'hAA; b = 8'h55; cin = 1'b1;
    end else begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      start = 1'b0;
    end
    check("busy_after_accept", 32'(busy), 32'd1);
    check("sum_cleared", 32'(sum), 32'd0);
    busy_n = 1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (busy === 1'b1) busy_n++;
    end
    check("latency_edges", 32'(n + 1), 32'(WIDTH + 1));
    tick();
    start = 1'b0;
    check("busy_fall", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_cycles", 32'(busy_n), 32'(WIDTH + 1));
    check("done_count", 32'(done_cnt - d0), 32'd1);
    tick();
    check("no_restart", 32'(busy), 32'd0);
    check("hold", {23'd0, cout, sum}, {23'd0, exp_r});
    $display("[TB] op a=%0h b=%0h cin=%0b -> sum=%0h cout=%0b", av, bv, cv, sum, cout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum_cout", {23'd0, cout, sum}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic
    do_op(8'h35, 8'h4A, 1'b0, 1'b0);
    // Wrap-around
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    // Start while busy
    do_op(8'h10, 8'h20, 1'b0, 1'b1);

    // Reset mid-operation
    a = 8'h0F; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum_cout", {23'd0, cout, sum}, 32'd0);
    $display("[TB] mid-op reset: busy=%0b done=%0b sum=%0h cout=%0b", busy, done, sum, cout);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("postrst_idle", 32'(busy), 32'd0);
    end
    check("postrst_no_done", 32'(done_cnt - d0), 32'd0);
    do_op(8'h0F, 8'h0F, 1'b0, 1'b0);

    // Back-to-back with start held high
    d0 = done_cnt;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int p;
      p = k % (WIDTH + 2);
      tick();
      if (p == 0) sb.push_back(9'd3);
      check("b2b_busy", 32'(busy), (p <= WIDTH) ? 32'd1 : 32'd0);
      check("b2b_done", 32'(done), (p == WIDTH) ? 32'd1 : 32'd0);
      if (p >= WIDTH) check("b2b_hold", {23'd0, cout, sum}, 32'd3);
    end
    start = 1'b0;
    tick();
    check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
    tick();

    // Random sweep
    for (int k = 0; k < 24; k++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    end

    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
